inv_shift_row_stage: RTL and testbench

// - Registered InvShiftRows stage for the AES-128 decryption datapath; counterpart of the encrypt-side ShiftRows stage.
// - Applies the inverse byte permutation to the 128-bit state and carries round key, Rcon and empty flag alongside, unmodified.
// - The optional key-rotation feature is the only exception to the unmodified key (see CONFIGURATION).
// - Valid/ready on both sides, 2-entry skid buffer; tags each beat with a wrapping round index.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_skid_buf.sv | 69 ++++++
 rtl/inv_shift_row_stage.sv | 96 +++++++++
 tb/tb_inv_shift_row_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and the InvShiftRows byte permutation.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned ROUND_W   = 4;

    typedef logic [7:0]       aes_byte_t;
    typedef aes_byte_t [15:0] aes_state_t;   // byte k = [8k+7:8k], row r = bytes 4r..4r+3

    // One beat as stored in the stage registers (state already permuted).
    typedef struct packed {
        aes_state_t          state;
        aes_state_t          key;
        aes_byte_t           rcon;
        logic                empty;
        logic [ROUND_W-1:0]  round_idx;
        logic                last_round;
    } stage_beat_t;

    // Row r is rotated right by r byte positions: o[4r+c] = i[4r + (c-r) mod 4].
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[4'(4 * r + c)] = s[4'(4 * r + ((c + 4 - r) % 4))];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_skid_buf.sv
// Two-entry valid/ready skid buffer; main drives the outputs, skid absorbs one beat of backpressure.
module aes_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_q,       main_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_q,       skid_d;
    logic         accept_c;
    logic         drain_c;

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;
    assign accept_c  = in_valid && !skid_valid_q;
    assign drain_c   = main_valid_q && out_ready;

    // Next-state: refill main from skid first, otherwise from the input; overflow goes to skid.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (drain_c) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                main_d       = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = in_data;
            end
        end
    end

    // Storage registers; reset drops any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/inv_shift_row_stage.sv
// Registered InvShiftRows stage for AES-128 decryption with 2-entry skid and round tagging.
// Optional: define INV_SHIFT_ROW_KEYROT_EN to rotate key word 3 right by one byte.
module inv_shift_row_stage
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon_in,
    input  logic         empty_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [127:0] key_out,
    output logic [7:0]   rcon_out,
    output logic         empty_out,
    output logic [3:0]   round_idx,
    output logic         last_round
);

    localparam int unsigned BEAT_W = $bits(stage_beat_t);
    localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NR - 1);

    logic [ROUND_W-1:0] cnt_q, cnt_d;
    logic               accept_c;
    aes_state_t         key_c;
    stage_beat_t        beat_in;
    stage_beat_t        beat_out;

    assign accept_c = in_valid && in_ready;

    // Key pass-through, optionally undoing the encrypt-side RotWord on word 3.
    always_comb begin
        key_c = aes_state_t'(key_in);
`ifdef INV_SHIFT_ROW_KEYROT_EN
        key_c[12] = key_in[127:120];
        key_c[13] = key_in[103:96];
        key_c[14] = key_in[111:104];
        key_c[15] = key_in[119:112];
`endif
    end

    // Beat assembly: permute on entry and tag with the current accept count.
    always_comb begin
        beat_in            = '0;
        beat_in.state      = inv_shift_rows(aes_state_t'(state_in));
        beat_in.key        = key_c;
        beat_in.rcon       = rcon_in;
        beat_in.empty      = empty_in;
        beat_in.round_idx  = cnt_q;
        beat_in.last_round = (cnt_q == LAST_IDX);
    end

    // Accept counter next-state: wraps NR-1 -> 0, bubbles included.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_c) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + ROUND_W'(1);
        end
    end

    // Accept counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    aes_skid_buf #(
        .W (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (beat_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (beat_out)
    );

    assign state_out  = beat_out.state;
    assign key_out    = beat_out.key;
    assign rcon_out   = beat_out.rcon;
    assign empty_out  = beat_out.empty;
    assign round_idx  = beat_out.round_idx;
    assign last_round = beat_out.last_round;

endmodule

// File: tb/tb_inv_shift_row_stage.sv
// Scoreboard bench for inv_shift_row_stage: permutation, round trip, backpressure, wrap, key rotation, reset.
module tb_inv_shift_row_stage;

    typedef struct {
        logic [127:0] state;
        logic [127:0] key;
        logic [7:0]   rcon;
        logic         empty;
        logic [3:0]   ridx;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic [7:0]   rcon_in;
    logic         empty_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic [7:0]   rcon_out;
    logic         empty_out;
    logic [3:0]   round_idx;
    logic         last_round;

    exp_t         sb[$];
    exp_t         e;
    int           checks = 0;
    int           errors = 0;
    int           model_cnt = 0;
    int           last_seen = 0;
    logic [127:0] exp_state_drv;

    localparam logic [127:0] SEQ = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    always #5 clk = ~clk;

    inv_shift_row_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .key_in     (key_in),
        .rcon_in    (rcon_in),
        .empty_in   (empty_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out),
        .key_out    (key_out),
        .rcon_out   (rcon_out),
        .empty_out  (empty_out),
        .round_idx  (round_idx),
        .last_round (last_round)
    );

    function automatic logic [127:0] model_inv(input logic [127:0] s);
        int src[16] = '{0, 1, 2, 3, 7, 4, 5, 6, 10, 11, 8, 9, 13, 14, 15, 12};
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = s[8*src[k] +: 8];
        return o;
    endfunction

    function automatic logic [127:0] model_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(4*r+c) +: 8] = s[8*(4*r + (c + r) % 4) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] model_key(input logic [127:0] k);
        logic [127:0] o;
        o = k;
`ifdef INV_SHIFT_ROW_KEYROT_EN
        o[103:96]  = k[127:120];
        o[111:104] = k[103:96];
        o[119:112] = k[111:104];
        o[127:120] = k[119:112];
`endif
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Monitor: pop/compare delivered beats, push expectations for accepted ones.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed=%h expected=none", state_out);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_state", state_out, e.state);
                    chk("sb_key", key_out, e.key);
                    chk("sb_rcon", 128'(rcon_out), 128'(e.rcon));
                    chk("sb_tag", 128'({empty_out, round_idx, last_round}), 128'({e.empty, e.ridx, e.last}));
                end
                if (last_round) last_seen++;
            end
            if (in_valid && in_ready) begin
                sb.push_back('{exp_state_drv, model_key(key_in), rcon_in, empty_in,
                               4'(model_cnt), (model_cnt == 9)});
                model_cnt = (model_cnt == 9) ? 0 : model_cnt + 1;
            end
        end
    end

    task automatic send(input logic [127:0] st, input logic [127:0] k, input logic [7:0] rc,
                        input logic em, input logic [127:0] exps);
        bit acc;
        acc           = 1'b0;
        state_in      = st;
        key_in        = k;
        rcon_in       = rc;
        empty_in      = em;
        exp_state_drv = exps;
        in_valid      = 1'b1;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_timeout observed=%0d expected=1", acc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_send(input logic [127:0] st);
        send(st, {$urandom(), $urandom(), $urandom(), $urandom()}, 8'($urandom()),
             1'($urandom()), model_inv(st));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] st;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        state_in = '0; key_in = '0; rcon_in = '0; empty_in = 1'b0; exp_state_drv = '0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_state", state_out, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Permutation of byte k = k, visible one cycle after acceptance.
        send(SEQ, SEQ, 8'h36, 1'b0, model_inv(SEQ));
        in_valid = 1'b0;
        chk("perm_valid", 128'(out_valid), 128'(1));
        chk("perm_state", state_out, 128'h0C0F0E0D_09080B0A_06050407_03020100);
        chk("perm_ridx", 128'(round_idx), 128'(0));
        tick(2);

        // Round trip: encrypt-side ShiftRows followed by this stage is the identity.
        for (int i = 0; i < 4; i++) begin
            st = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(model_shift_rows(st), {$urandom(), $urandom(), $urandom(), $urandom()},
                 8'($urandom()), 1'(i), st);
        end
        in_valid = 1'b0;
        tick(3);

        // Backpressure: two beats fill main and skid, the third is refused.
        out_ready = 1'b0;
        send(128'hA0, 128'h1, 8'h01, 1'b0, model_inv(128'hA0));
        send(128'hB0B1, 128'h2, 8'h02, 1'b1, model_inv(128'hB0B1));
        state_in = 128'hC0C1C2C3_C4C5C6C7; key_in = 128'h3; rcon_in = 8'h03; empty_in = 1'b0;
        exp_state_drv = model_inv(state_in);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_head", state_out, model_inv(128'hA0));
        tick(3);
        chk("bp_hold_state", state_out, model_inv(128'hA0));
        chk("bp_hold_valid", 128'({out_valid, in_ready}), 128'(2'b10));
        out_ready = 1'b1;
        send(128'hC0C1C2C3_C4C5C6C7, 128'h3, 8'h03, 1'b0, model_inv(128'hC0C1C2C3_C4C5C6C7));
        in_valid = 1'b0;
        tick(5);
        chk("bp_drained", 128'(sb.size()), 128'(0));

        // Round wrap over 21 back-to-back beats from a fresh counter.
        rst_n = 1'b0;
        #1;
        sb.delete(); model_cnt = 0; last_seen = 0;
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 21; i++) rand_send({$urandom(), $urandom(), $urandom(), $urandom()});
        in_valid = 1'b0;
        tick(4);
        chk("wrap_drained", 128'(sb.size()), 128'(0));
        chk("wrap_last_count", 128'(last_seen), 128'(2));

        // Key word 3 handling.
        send(SEQ, SEQ, 8'h1B, 1'b0, model_inv(SEQ));
        in_valid = 1'b0;
`ifdef INV_SHIFT_ROW_KEYROT_EN
        chk("keyrot", key_out, 128'h0E0D0C0F_0B0A0908_07060504_03020100);
`else
        chk("keyrot", key_out, SEQ);
`endif
        tick(3);

        // Reset mid-stream with the skid full.
        out_ready = 1'b0;
        rand_send(128'h1111);
        rand_send(128'h2222);
        in_valid = 1'b0;
        chk("mid_full", 128'(in_ready), 128'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ports", 128'({out_valid, in_ready}), 128'(2'b01));
        chk("mid_rst_state", state_out, '0);
        sb.delete(); model_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        out_ready = 1'b1;
        rand_send(128'h3333);
        in_valid = 1'b0;
        chk("post_rst_ridx", 128'({out_valid, round_idx}), 128'({1'b1, 4'd0}));
        tick(3);
        chk("final_drained", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
